// File: rtl/pio_hub.sv
// pio_hub: memory-mapped parallel I/O block with switch sampling, LED drive,
// debounced push-buttons with rising-edge capture, and a masked level IRQ.
module pio_hub #(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned LED_WIDTH       = 8,
  parameter int unsigned KEY_COUNT       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [2:0]           AVL_ADDR,
  input  logic                 AVL_CS,
  input  logic                 AVL_READ,
  input  logic                 AVL_WRITE,
  input  logic [31:0]          AVL_WRITEDATA,
  output logic [31:0]          AVL_READDATA,
  output logic                 IRQ,
  input  logic [SW_WIDTH-1:0]  SW,
  input  logic [KEY_COUNT-1:0] KEY,
  output logic [LED_WIDTH-1:0] LEDR
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_SW   = 3'd0;
  localparam logic [2:0] ADDR_LED  = 3'd1;
  localparam logic [2:0] ADDR_SET  = 3'd2;
  localparam logic [2:0] ADDR_CLR  = 3'd3;
  localparam logic [2:0] ADDR_KEY  = 3'd4;
  localparam logic [2:0] ADDR_CAP  = 3'd5;
  localparam logic [2:0] ADDR_MASK = 3'd6;

  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic [KEY_COUNT-1:0] r_key_meta;
  logic [KEY_COUNT-1:0] r_key_sync;
  logic [KEY_COUNT-1:0] r_db;
  logic [CNT_W-1:0]     r_cnt [KEY_COUNT];
  logic [KEY_COUNT-1:0] r_cap;
  logic [KEY_COUNT-1:0] r_mask;
  logic [LED_WIDTH-1:0] r_led;
  logic [31:0]          r_rdata;
  logic                 r_irq;

  logic                 w_rd;
  logic                 w_wr;
  logic [LED_WIDTH-1:0] w_wdata_led;
  logic [KEY_COUNT-1:0] w_wdata_key;
  logic [KEY_COUNT-1:0] w_toggle;
  logic [KEY_COUNT-1:0] w_rise;
  logic [31:0]          w_rdata;
  logic                 w_unused_wdata;

  assign w_rd           = AVL_CS & AVL_READ;
  assign w_wr           = AVL_CS & AVL_WRITE;
  assign w_wdata_led    = AVL_WRITEDATA[LED_WIDTH-1:0];
  assign w_wdata_key    = AVL_WRITEDATA[KEY_COUNT-1:0];
  assign w_unused_wdata = ^AVL_WRITEDATA;

  assign AVL_READDATA = r_rdata;
  assign IRQ          = r_irq;
  assign LEDR         = r_led;

  // Two-flop synchronizers; keys are inverted first so a cleared
  // synchronizer reads as "released" rather than as a phantom press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_key_meta <= '0;
      r_key_sync <= '0;
    end else begin
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
      r_key_meta <= ~KEY;
      r_key_sync <= r_key_meta;
    end
  end

  // Per-key toggle decision and press (0->1) detection.
  always_comb begin
    w_toggle = '0;
    w_rise   = '0;
    for (int i = 0; i < int'(KEY_COUNT); i++) begin
      w_toggle[i] = (r_key_sync[i] != r_db[i]) && (r_cnt[i] == CNT_LAST);
      w_rise[i]   = w_toggle[i] & ~r_db[i];
    end
  end

  // Debouncers: count consecutive mismatched cycles, flip level on the last one.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_db <= '0;
      for (int i = 0; i < int'(KEY_COUNT); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(KEY_COUNT); i++) begin
        if (r_key_sync[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (w_toggle[i]) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge capture with write-1-to-clear; a new capture wins over a clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cap <= '0;
    end else if (w_wr && (AVL_ADDR == ADDR_CAP)) begin
      r_cap <= (r_cap & ~w_wdata_key) | w_rise;
    end else begin
      r_cap <= r_cap | w_rise;
    end
  end

  // IRQ mask register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mask <= '0;
    end else if (w_wr && (AVL_ADDR == ADDR_MASK)) begin
      r_mask <= w_wdata_key;
    end
  end

  // LED register with direct, set and clear write ports.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_led <= '0;
    end else if (w_wr) begin
      case (AVL_ADDR)
        ADDR_LED: r_led <= w_wdata_led;
        ADDR_SET: r_led <= r_led | w_wdata_led;
        ADDR_CLR: r_led <= r_led & ~w_wdata_led;
        default:  ;
      endcase
    end
  end

  // Read mux over current (pre-write) register state.
  always_comb begin
    w_rdata = '0;
    case (AVL_ADDR)
      ADDR_SW:   w_rdata = 32'(r_sw_sync);
      ADDR_LED:  w_rdata = 32'(r_led);
      ADDR_KEY:  w_rdata = 32'(r_db);
      ADDR_CAP:  w_rdata = 32'(r_cap);
      ADDR_MASK: w_rdata = 32'(r_mask);
      default:   w_rdata = '0;
    endcase
  end

  // Registered read data; holds between reads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

endmodule

// File: tb/tb_pio_hub.sv
// tb_pio_hub: table vectors, directed corner sequences and randomized
// stimulus checked against a behavioural model of pio_hub.
module tb_pio_hub;

  localparam int unsigned D = 4;

  logic        Clk;
  logic        Reset;
  logic [2:0]  AVL_ADDR;
  logic        AVL_CS;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        IRQ;
  logic [7:0]  SW;
  logic [1:0]  KEY;
  logic [7:0]  LEDR;

  int checks;
  int errors;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t tbl [16];

  // model state
  logic [1:0]  p1, p2, seen, pressed, db_m, cap_m, mask_m, rise, wd;
  logic        irq_m, irq_nx, all_mis;
  logic [1:0]  win [$];
  logic [7:0]  led_m;
  logic [31:0] rd, exp_rd;
  logic [2:0]  a;
  int          op;

  pio_hub #(
    .SW_WIDTH(8), .LED_WIDTH(8), .KEY_COUNT(2), .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clk(Clk), .Reset(Reset), .AVL_ADDR(AVL_ADDR), .AVL_CS(AVL_CS),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .IRQ(IRQ), .SW(SW), .KEY(KEY), .LEDR(LEDR)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr; AVL_WRITEDATA = data;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    data = AVL_READDATA;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1; AVL_ADDR = '0; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_WRITEDATA = '0; SW = '0; KEY = 2'b11;

    // reset state, before any clock edge
    #1;
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    check("rst_rdata", AVL_READDATA, 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // register-access vectors
    tbl[0]  = '{1'b1, 3'd1, 32'h0000_00A5, 32'h0, 8'hA5};
    tbl[1]  = '{1'b1, 3'd2, 32'h0000_000F, 32'h0, 8'hAF};
    tbl[2]  = '{1'b1, 3'd3, 32'h0000_0081, 32'h0, 8'h2E};
    tbl[3]  = '{1'b0, 3'd1, 32'h0, 32'h0000_002E, 8'h2E};
    tbl[4]  = '{1'b0, 3'd2, 32'h0, 32'h0, 8'h2E};
    tbl[5]  = '{1'b0, 3'd3, 32'h0, 32'h0, 8'h2E};
    tbl[6]  = '{1'b0, 3'd7, 32'h0, 32'h0, 8'h2E};
    tbl[7]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 8'h2E};
    tbl[8]  = '{1'b1, 3'd1, 32'h1234_5678, 32'h0, 8'h78};
    tbl[9]  = '{1'b0, 3'd1, 32'h0, 32'h0000_0078, 8'h78};
    tbl[10] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, 8'h78};
    tbl[11] = '{1'b0, 3'd6, 32'h0, 32'h0000_0003, 8'h78};
    tbl[12] = '{1'b1, 3'd4, 32'h0000_00FF, 32'h0, 8'h78};
    tbl[13] = '{1'b0, 3'd4, 32'h0, 32'h0, 8'h78};
    tbl[14] = '{1'b1, 3'd0, 32'h0000_00FF, 32'h0, 8'h78};
    tbl[15] = '{1'b0, 3'd5, 32'h0, 32'h0, 8'h78};
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
      end else begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      end
      check($sformatf("tbl%0d_ledr", i), 32'(LEDR), 32'(tbl[i].exp_led));
    end

    // simultaneous read+write returns pre-write data
    @(negedge Clk);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 3'd1; AVL_WRITEDATA = 32'h55;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    check("rw_rdata", AVL_READDATA, 32'h78);
    check("rw_ledr", 32'(LEDR), 32'h55);
    // read strobe without chip select: data holds
    AVL_READ = 1'b1; AVL_ADDR = 3'd6;
    @(negedge Clk);
    AVL_READ = 1'b0;
    check("nocs_hold", AVL_READDATA, 32'h78);
    bus_write(3'd6, 32'h0);

    // switches
    SW = 8'h3C;
    @(negedge Clk);
    bus_read(3'd0, rd);
    check("sw_read", rd, 32'h3C);

    // debounce latency on key 0, read every cycle
    @(negedge Clk);
    KEY = 2'b10; AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 3'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      check($sformatf("deb_lat%0d", k), AVL_READDATA, (k >= 7) ? 32'h1 : 32'h0);
    end
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    bus_read(3'd5, rd);
    check("deb_cap", rd, 32'h1);

    // 3-cycle glitch on key 1 is rejected
    @(negedge Clk);
    KEY = 2'b00;
    repeat (3) @(negedge Clk);
    KEY = 2'b10;
    repeat (8) @(negedge Clk);
    bus_read(3'd4, rd);
    check("glitch_db", rd, 32'h1);
    bus_read(3'd5, rd);
    check("glitch_cap", rd, 32'h1);

    // interrupt enable and clear
    check("irq_masked", 32'(IRQ), 32'h0);
    bus_write(3'd6, 32'h1);
    check("irq_mask_edge", 32'(IRQ), 32'h0);
    @(negedge Clk);
    check("irq_set", 32'(IRQ), 32'h1);
    bus_write(3'd5, 32'h1);
    check("irq_clr_edge", 32'(IRQ), 32'h1);
    @(negedge Clk);
    check("irq_cleared", 32'(IRQ), 32'h0);
    bus_read(3'd5, rd);
    check("cap_cleared", rd, 32'h0);

    // release does not capture
    KEY = 2'b11;
    repeat (8) @(negedge Clk);
    bus_read(3'd4, rd);
    check("rel_db", rd, 32'h0);
    bus_read(3'd5, rd);
    check("rel_cap", rd, 32'h0);

    // clear collides with a new capture: capture wins
    @(negedge Clk);
    KEY = 2'b10;
    repeat (5) @(negedge Clk);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 3'd5; AVL_WRITEDATA = 32'h1;
    @(negedge Clk);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    bus_read(3'd5, rd);
    check("coll_cap", rd, 32'h1);
    check("coll_irq", 32'(IRQ), 32'h1);
    KEY = 2'b11;
    repeat (8) @(negedge Clk);

    // randomized key/cap/mask traffic against the model
    do_reset();
    p1 = '0; p2 = '0; db_m = '0; cap_m = '0; mask_m = '0; irq_m = 1'b0; pressed = '0;
    win.delete();
    for (int c = 0; c < 700; c++) begin
      if (c >= 660) pressed = 2'b00;
      else if ($urandom_range(7) == 0) pressed = 2'($urandom);
      op = int'($urandom_range(7));
      wd = 2'($urandom);
      KEY = ~pressed;
      AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
      AVL_WRITEDATA = {30'($urandom), wd};
      case (op)
        0, 1: begin AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 3'd4; end
        2, 3: begin AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 3'd5; end
        4:    begin AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 3'd6; end
        5:    begin AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 3'd5; end
        default: ;
      endcase
      exp_rd = (op < 2) ? 32'(db_m) : 32'(cap_m);
      // level accepted once the synchronized level differs from it for D straight cycles
      irq_nx = |(cap_m & mask_m);
      seen = p2; p2 = p1; p1 = pressed;
      win.push_back(seen);
      if (win.size() > D) void'(win.pop_front());
      rise = '0;
      if (win.size() == D) begin
        for (int i = 0; i < 2; i++) begin
          all_mis = 1'b1;
          foreach (win[k]) if (win[k][i] == db_m[i]) all_mis = 1'b0;
          if (all_mis) begin
            db_m[i] = ~db_m[i];
            rise[i] = db_m[i];
          end
        end
      end
      if (op == 5) cap_m = cap_m & ~wd;
      cap_m = cap_m | rise;
      if (op == 4) mask_m = wd;
      irq_m = irq_nx;
      @(negedge Clk);
      if (op < 4) check((op < 2) ? "rand_db" : "rand_cap", AVL_READDATA, exp_rd);
      check("rand_irq", 32'(IRQ), 32'(irq_m));
    end
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;

    // randomized LED/mask/switch register traffic
    do_reset();
    led_m = '0; mask_m = '0;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(7));
      exp_rd = $urandom;
      case (op)
        0: begin bus_write(3'd1, exp_rd); led_m = exp_rd[7:0]; end
        1: begin bus_write(3'd2, exp_rd); led_m = led_m | exp_rd[7:0]; end
        2: begin bus_write(3'd3, exp_rd); led_m = led_m & ~exp_rd[7:0]; end
        3: begin bus_write(3'd6, exp_rd); mask_m = exp_rd[1:0]; end
        4: begin bus_read(3'd1, rd); check("rnd_led_rd", rd, 32'(led_m)); end
        5: begin bus_read(3'd6, rd); check("rnd_mask_rd", rd, 32'(mask_m)); end
        6: begin
          case ($urandom_range(2))
            0: a = 3'd2;
            1: a = 3'd3;
            default: a = 3'd7;
          endcase
          bus_write(3'd7, exp_rd);
          bus_read(a, rd);
          check("rnd_zero_rd", rd, 32'h0);
        end
        default: begin
          SW = 8'($urandom);
          @(negedge Clk);
          bus_read(3'd0, rd);
          check("rnd_sw_rd", rd, 32'(SW));
        end
      endcase
      check("rnd_ledr", 32'(LEDR), 32'(led_m));
    end

    // asynchronous reset in the middle of activity
    bus_write(3'd6, 32'h1);
    KEY = 2'b10;
    repeat (8) @(negedge Clk);
    bus_write(3'd1, 32'hFF);
    bus_read(3'd1, rd);
    check("pre_rst_rd", rd, 32'hFF);
    KEY = 2'b00;
    @(negedge Clk);
    @(negedge Clk);
    check("pre_rst_irq", 32'(IRQ), 32'h1);
    check("pre_rst_ledr", 32'(LEDR), 32'hFF);
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_ledr", 32'(LEDR), 32'h0);
    check("mid_rst_irq", 32'(IRQ), 32'h0);
    check("mid_rst_rdata", AVL_READDATA, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    // keys held through reset are accepted after the full count
    Reset = 1'b0;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 3'd4;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      check($sformatf("held_lat%0d", k), AVL_READDATA, (k >= 7) ? 32'h3 : 32'h0);
    end
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    bus_read(3'd5, rd);
    check("held_cap", rd, 32'h3);
    bus_read(3'd6, rd);
    check("held_mask", rd, 32'h0);
    check("held_irq", 32'(IRQ), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
